// File: rtl/kdf_run_controller_if.sv
// Bundle between the autotest harness and the KDF run controller: the vector/start
// request, the KDF core connection, and the result signals reported back.
interface kdf_run_controller_if #(
    parameter int SALT_W  = 64,
    parameter int COUNT_W = 32,
    parameter int PWD_W   = 32,
    parameter int KEY_W   = 128
);
    logic               start_i;
    logic [SALT_W-1:0]  salt_i;
    logic [COUNT_W-1:0] count_i;
    logic [PWD_W-1:0]   password_i;
    logic               uut_end_i;
    logic [KEY_W-1:0]   uut_key_i;

    logic               uut_rst_o;
    logic [SALT_W-1:0]  uut_salt_o;
    logic [COUNT_W-1:0] uut_count_o;
    logic [PWD_W-1:0]   uut_pwd_o;
    logic               busy_o;
    logic               done_o;
    logic               timeout_o;
    logic [KEY_W-1:0]   key_o;
    logic [31:0]        cycles_o;

    modport master (
        output start_i, salt_i, count_i, password_i, uut_end_i, uut_key_i,
        input  uut_rst_o, uut_salt_o, uut_count_o, uut_pwd_o,
        input  busy_o, done_o, timeout_o, key_o, cycles_o
    );

    modport slave (
        input  start_i, salt_i, count_i, password_i, uut_end_i, uut_key_i,
        output uut_rst_o, uut_salt_o, uut_count_o, uut_pwd_o,
        output busy_o, done_o, timeout_o, key_o, cycles_o
    );
endinterface

// File: rtl/kdf_run_controller.sv
// Run sequencer for the KDF core: latches a vector, holds the core in reset, releases
// it, then captures the derived key and run latency, aborting on a cycle timeout.
module kdf_run_controller #(
    parameter int SALT_W     = 64,
    parameter int COUNT_W    = 32,
    parameter int PWD_W      = 32,
    parameter int KEY_W      = 128,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 50_000_000
) (
    input logic clk,
    input logic rst,
    kdf_run_controller_if.slave bus
);
    localparam int          RW        = $clog2(RST_CYCLES + 1);
    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RESET_UUT, RUN, DONE} state_t;

    state_t             state_q;
    logic [RW-1:0]      rst_cnt_q;
    logic [31:0]        run_cnt_q;
    logic               uut_rst_q;
    logic               busy_q;
    logic               done_q;
    logic               timeout_q;
    logic [KEY_W-1:0]   key_q;
    logic [31:0]        cycles_q;
    logic [SALT_W-1:0]  salt_q;
    logic [COUNT_W-1:0] count_q;
    logic [PWD_W-1:0]   pwd_q;

    // The run counter is preloaded with 1 so it already reads the 1-based cycle
    // number inside RUN; leaving RUN at TIMEOUT keeps it from ever wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rst_cnt_q <= '0;
            run_cnt_q <= '0;
            uut_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            key_q     <= '0;
            cycles_q  <= '0;
            salt_q    <= '0;
            count_q   <= '0;
            pwd_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        state_q   <= RESET_UUT;
                        salt_q    <= bus.salt_i;
                        count_q   <= bus.count_i;
                        pwd_q     <= bus.password_i;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        key_q     <= '0;
                        cycles_q  <= '0;
                        rst_cnt_q <= RW'(RST_CYCLES - 1);
                        busy_q    <= 1'b1;
                        uut_rst_q <= 1'b1;
                    end
                end
                RESET_UUT: begin
                    if (rst_cnt_q == '0) begin
                        state_q   <= RUN;
                        uut_rst_q <= 1'b0;
                        run_cnt_q <= 32'd1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 1'b1;
                    end
                end
                RUN: begin
                    // A core finishing on the very last allowed cycle still counts as success.
                    if (bus.uut_end_i) begin
                        key_q     <= bus.uut_key_i;
                        cycles_q  <= run_cnt_q;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        uut_rst_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (run_cnt_q == TIMEOUT_C) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        key_q     <= '0;
                        cycles_q  <= TIMEOUT_C;
                        busy_q    <= 1'b0;
                        uut_rst_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        run_cnt_q <= run_cnt_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.uut_rst_o   = uut_rst_q;
    assign bus.uut_salt_o  = salt_q;
    assign bus.uut_count_o = count_q;
    assign bus.uut_pwd_o   = pwd_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.timeout_o   = timeout_q;
    assign bus.key_o       = key_q;
    assign bus.cycles_o    = cycles_q;
endmodule
